// File: rtl/sum_of_squares_acc.sv
// ---------------------------------------------------------------------------
// sum_of_squares_acc
//
// Purpose:
//   Stage that sits directly after the 3-bit squarer. It takes one 6-bit
//   square per valid/ready handshake and adds N_SAMPLES of them into a block
//   sum, which gives the energy of a block of 3-bit samples. The finished sum
//   is offered downstream through a valid/ready handshake. The block also
//   flags input words that cannot be the square of a 3-bit value, and it
//   flags any saturation of the accumulator.
//
// Parameters:
//   N_SAMPLES : squares per block, 1..255
//   ACC_W     : accumulator / result width. The result saturates at
//               2^ACC_W-1 when ACC_W is too small for the block.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   clear      in   synchronous abort of the partial block (ignored in HOLD)
//   sq_in      in   square from the upstream squarer (0..49 when legal)
//   sq_valid   in   sq_in valid
//   sq_ready   out  a square can be accepted this cycle
//   sum_out    out  block sum, stable while sum_valid=1
//   sum_valid  out  block sum available
//   sum_ready  in   downstream takes sum_out
//   count      out  squares accepted in the current block
//   bad_sample out  sticky until rst: a non-square word was accepted
//   overflow   out  sticky for the current block: saturation occurred
// ---------------------------------------------------------------------------
module sum_of_squares_acc #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [5:0]       sq_in,
  input  logic             sq_valid,
  output logic             sq_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [7:0]       count,
  output logic             bad_sample,
  output logic             overflow
);

  // The adder must be wide enough for both operands plus one carry bit.
  // The 6-bit input sets the floor when ACC_W is very small.
  localparam int SUM_W = ((ACC_W > 6) ? ACC_W : 6) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << ACC_W) - 64'd1);
  localparam logic [7:0]       LAST_IDX = 8'(N_SAMPLES - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_count;
  logic [ACC_W-1:0] r_sum_out;
  logic             r_sum_valid;
  logic             r_sq_ready;
  logic             r_bad_sample;
  logic             r_overflow;

  // -------------------------------------------------------------------------
  // Combinational datapath
  // -------------------------------------------------------------------------
  logic [SUM_W-1:0] w_sum;
  logic             w_sat_hit;
  logic [ACC_W-1:0] w_sat_val;
  logic [7:0]       w_legal_hit;
  logic             w_illegal;
  logic             w_accept;
  logic             w_last;

  assign w_sum     = SUM_W'(r_acc) + SUM_W'(sq_in);
  assign w_sat_hit = (w_sum > SAT_MAX);
  assign w_sat_val = w_sat_hit ? SAT_MAX[ACC_W-1:0] : w_sum[ACC_W-1:0];

  // One comparator per legal square 0,1,4,...,49. A word is illegal
  // when none of them matches.
  for (genvar gi = 0; gi < 8; gi++) begin : g_legal
    assign w_legal_hit[gi] = (sq_in == 6'(gi * gi));
  end
  assign w_illegal = ~(|w_legal_hit);

  // r_sq_ready is high only in ACCUM, so an accept implies ACCUM.
  assign w_accept = sq_valid && r_sq_ready;
  assign w_last   = (r_count == LAST_IDX);

  // -------------------------------------------------------------------------
  // Control FSM and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACCUM;
      r_acc        <= '0;
      r_count      <= '0;
      r_sum_out    <= '0;
      r_sum_valid  <= 1'b0;
      r_sq_ready   <= 1'b1;
      r_bad_sample <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (clear) begin
            // Abort wins over a same-cycle accept. The word is dropped
            // completely, so it does not touch bad_sample either.
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end else if (w_accept) begin
            if (w_illegal) begin
              r_bad_sample <= 1'b1;
            end
            if (w_sat_hit) begin
              r_overflow <= 1'b1;
            end
            if (w_last) begin
              // The closing sample goes straight into the result, so the
              // sum is valid one cycle after the Nth accept.
              r_sum_out   <= w_sat_val;
              r_acc       <= '0;
              r_count     <= '0;
              r_sum_valid <= 1'b1;
              r_sq_ready  <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc   <= w_sat_val;
              r_count <= r_count + 8'd1;
            end
          end
        end

        ST_HOLD: begin
          // The consume edge returns to ACCUM, but sq_ready comes back
          // only on the next cycle. That leaves one bubble cycle, and
          // there is no restart in the same cycle.
          if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
            r_sq_ready  <= 1'b1;
            r_overflow  <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end

        default: begin
          r_state     <= ST_ACCUM;
          r_sum_valid <= 1'b0;
          r_sq_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign sq_ready   = r_sq_ready;
  assign sum_out    = r_sum_out;
  assign sum_valid  = r_sum_valid;
  assign count      = r_count;
  assign bad_sample = r_bad_sample;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sum_of_squares_acc.sv
// Directed testbench for sum_of_squares_acc.
// dut_a uses the default parameters (N=8, ACC_W=9).
// dut_s uses ACC_W=7 and the same stimulus, to exercise saturation.
module tb_sum_of_squares_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [5:0] sq_in;
  logic       sq_valid;
  logic       sum_ready;

  logic       a_sq_ready, a_sum_valid, a_bad, a_ovf;
  logic [8:0] a_sum_out;
  logic [7:0] a_count;

  logic       s_sq_ready, s_sum_valid, s_bad, s_ovf;
  logic [6:0] s_sum_out;
  logic [7:0] s_count;

  int checks = 0;
  int errors = 0;
  int blk [8];

  always #5 clk = ~clk;

  sum_of_squares_acc #(.N_SAMPLES(8), .ACC_W(9)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .sq_in(sq_in), .sq_valid(sq_valid),
    .sq_ready(a_sq_ready), .sum_out(a_sum_out), .sum_valid(a_sum_valid),
    .sum_ready(sum_ready), .count(a_count), .bad_sample(a_bad), .overflow(a_ovf)
  );

  sum_of_squares_acc #(.N_SAMPLES(8), .ACC_W(7)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .sq_in(sq_in), .sq_valid(sq_valid),
    .sq_ready(s_sq_ready), .sum_out(s_sum_out), .sum_valid(s_sum_valid),
    .sum_ready(sum_ready), .count(s_count), .bad_sample(s_bad), .overflow(s_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends blk[0..7] back to back and checks count after each accept.
  // sq_valid is left low at the end.
  task automatic run_block(input string tag);
    for (int i = 0; i < 8; i++) begin
      sq_valid = 1'b1;
      sq_in    = 6'(blk[i]);
      step();
      if (i < 7) begin
        check_val({tag, "_count"}, 32'(a_count), 32'(i + 1));
        check_val({tag, "_nvalid"}, 32'(a_sum_valid), 32'd0);
      end
    end
    sq_valid = 1'b0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) blk[i] = i * i;
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < 8; i++) blk[i] = v;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; sq_in = '0; sq_valid = 1'b0; sum_ready = 1'b1;
    step(); step();
    check_val("rst_sum_valid", 32'(a_sum_valid), 32'd0);
    check_val("rst_sq_ready", 32'(a_sq_ready), 32'd1);
    check_val("rst_count", 32'(a_count), 32'd0);
    check_val("rst_sum_out", 32'(a_sum_out), 32'd0);
    check_val("rst_bad", 32'(a_bad), 32'd0);
    check_val("rst_ovf", 32'(a_ovf), 32'd0);
    rst = 1'b0;
    step();
    check_val("post_rst_ready", 32'(a_sq_ready), 32'd1);

    // Single block 0..49, sum 140. The ACC_W=7 copy saturates to 127.
    set_ramp();
    run_block("single");
    check_val("single_valid", 32'(a_sum_valid), 32'd1);
    check_val("single_sum", 32'(a_sum_out), 32'd140);
    check_val("single_ovf", 32'(a_ovf), 32'd0);
    check_val("single_bad", 32'(a_bad), 32'd0);
    check_val("single_ready_low", 32'(a_sq_ready), 32'd0);
    check_val("single_count_wrap", 32'(a_count), 32'd0);
    check_val("sat_sum", 32'(s_sum_out), 32'd127);
    check_val("sat_ovf", 32'(s_ovf), 32'd1);
    step();
    check_val("single_valid_1cyc", 32'(a_sum_valid), 32'd0);
    check_val("single_ready_back", 32'(a_sq_ready), 32'd1);
    check_val("sat_ovf_cleared", 32'(s_ovf), 32'd0);

    // After a saturated block, a block of eight 1s gives a clean 8.
    set_const(1);
    run_block("ones");
    check_val("ones_sum", 32'(a_sum_out), 32'd8);
    check_val("sat_ones_sum", 32'(s_sum_out), 32'd127 & 32'd8);
    check_val("sat_ones_ovf", 32'(s_ovf), 32'd0);
    step();

    // Backpressure: the result is held while upstream keeps pushing, and
    // clear is ignored in HOLD.
    sum_ready = 1'b0;
    set_ramp();
    run_block("bp");
    sq_valid = 1'b1; sq_in = 6'd25;
    for (int k = 0; k < 5; k++) begin
      clear = (k == 2);
      step();
      check_val("bp_hold_valid", 32'(a_sum_valid), 32'd1);
      check_val("bp_hold_sum", 32'(a_sum_out), 32'd140);
      check_val("bp_hold_ready", 32'(a_sq_ready), 32'd0);
      check_val("bp_hold_count", 32'(a_count), 32'd0);
    end
    clear = 1'b0;
    sum_ready = 1'b1;
    step();
    check_val("bp_released_valid", 32'(a_sum_valid), 32'd0);
    check_val("bp_bubble_count", 32'(a_count), 32'd0);
    step();
    check_val("bp_next_accept", 32'(a_count), 32'd1);
    sq_valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("bp_clear_count", 32'(a_count), 32'd0);

    // Gapped input: eight 49s with sq_valid toggling. 8*49 = 392.
    for (int i = 0; i < 8; i++) begin
      sq_valid = 1'b1; sq_in = 6'd49;
      step();
      check_val("gap_count_acc", 32'(a_count), 32'((i + 1) % 8));
      if (i < 7) begin
        sq_valid = 1'b0;
        step();
        check_val("gap_count_idle", 32'(a_count), 32'(i + 1));
      end
    end
    sq_valid = 1'b0;
    check_val("gap_sum", 32'(a_sum_out), 32'd392);
    check_val("gap_valid", 32'(a_sum_valid), 32'd1);
    step();

    // Illegal word 2 as sample 3 with all other samples 1: sum 9, bad_sample set.
    set_const(1);
    blk[2] = 2;
    run_block("illegal");
    check_val("illegal_sum", 32'(a_sum_out), 32'd9);
    check_val("illegal_bad", 32'(a_bad), 32'd1);
    step();
    set_const(1);
    run_block("after_bad");
    check_val("after_bad_sum", 32'(a_sum_out), 32'd8);
    check_val("bad_sticky", 32'(a_bad), 32'd1);
    step();

    // Abort: three 9s, then clear together with 16, then eight 4s give 32.
    for (int i = 0; i < 3; i++) begin
      sq_valid = 1'b1; sq_in = 6'd9;
      step();
    end
    check_val("abort_pre_count", 32'(a_count), 32'd3);
    sq_in = 6'd16; clear = 1'b1;
    step();
    clear = 1'b0; sq_valid = 1'b0;
    check_val("abort_count", 32'(a_count), 32'd0);
    set_const(4);
    run_block("abort");
    check_val("abort_sum", 32'(a_sum_out), 32'd32);
    step();

    // clear also drops overflow that is still pending mid-block (ACC_W=7 copy).
    for (int i = 0; i < 3; i++) begin
      sq_valid = 1'b1; sq_in = 6'd49;
      step();
    end
    sq_valid = 1'b0;
    check_val("sat_mid_ovf", 32'(s_ovf), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("sat_clear_ovf", 32'(s_ovf), 32'd0);

    // Reset in the middle of a block.
    for (int i = 0; i < 5; i++) begin
      sq_valid = 1'b1; sq_in = 6'd4;
      step();
    end
    sq_valid = 1'b0;
    check_val("mid_count", 32'(a_count), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_count", 32'(a_count), 32'd0);
    check_val("mid_rst_valid", 32'(a_sum_valid), 32'd0);
    check_val("mid_rst_bad", 32'(a_bad), 32'd0);
    check_val("mid_rst_ready", 32'(a_sq_ready), 32'd1);
    set_ramp();
    run_block("post_rst");
    check_val("post_rst_sum", 32'(a_sum_out), 32'd140);
    check_val("post_rst_valid", 32'(a_sum_valid), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
